// File: rtl/dbg_uart_host_if.sv
// Command/response port of the UART debug host.
// master: command issuer; slave: dbg_uart_host.
interface dbg_uart_host_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;

    modport master (
        output cmd_valid_i, cmd_i, addr_i, data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, addr_i, data_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/dbg_uart_host.sv
// Host-side UART debug initiator: sends cmd[/addr[/data]], parses reply.
// Ports: clk, rstn_i (async low), tx_o, rx_i, bus (cmd/rsp, slave modport).

// 8N1 transmitter: tx_done_o pulses once at the end of the stop bit.
module uart_tx (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [31:0] clk_div_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_done_o,
    output logic        tx_o
);
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  idx;
    logic [8:0]  sh;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            busy      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '1;
            tx_done_o <= 1'b0;
            tx_o      <= 1'b1;
        end else begin
            tx_done_o <= 1'b0;
            if (!busy) begin
                cnt <= '0;
                // skip the done cycle so a still-held valid is not resent
                if (tx_valid_i && !tx_done_o) begin
                    busy <= 1'b1;
                    tx_o <= 1'b0;
                    sh   <= {1'b1, tx_data_i};
                    idx  <= '0;
                end
            end else if (cnt == clk_div_i - 32'd1) begin
                cnt <= '0;
                if (idx == 4'd9) begin
                    busy      <= 1'b0;
                    tx_done_o <= 1'b1;
                end else begin
                    tx_o <= sh[0];
                    sh   <= {1'b1, sh[8:1]};
                    idx  <= idx + 4'd1;
                end
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule

// 8N1 receiver: samples mid-bit; rx_err_o flags a low stop bit.
module uart_rx (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [31:0] clk_div_i,
    input  logic        rx_enable_i,
    input  logic        rx_i,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_err_o
);
    logic [1:0]  sync;
    logic        rx_s;
    logic        busy;
    logic [31:0] cnt;
    logic [31:0] tgt;
    logic [3:0]  idx;
    logic [7:0]  sh;

    assign rx_s = sync[1];
    // idx 0 is the start bit, checked half a bit in
    assign tgt  = (idx == 4'd0) ? (clk_div_i >> 1) : (clk_div_i - 32'd1);

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            sync       <= 2'b11;
            busy       <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_err_o   <= 1'b0;
        end else begin
            sync       <= {sync[0], rx_i};
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
            if (!busy) begin
                cnt <= '0;
                idx <= '0;
                if (rx_enable_i && !rx_s) busy <= 1'b1;
            end else if (cnt == tgt) begin
                cnt <= '0;
                idx <= idx + 4'd1;
                if (idx == 4'd0) begin
                    if (rx_s) busy <= 1'b0;
                end else if (idx == 4'd9) begin
                    busy       <= 1'b0;
                    rx_valid_o <= 1'b1;
                    rx_data_o  <= sh;
                    rx_err_o   <= !rx_s;
                end else begin
                    sh <= {rx_s, sh[7:1]};
                end
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule

module dbg_uart_host #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUDRATE = 115200,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic [7:0]  END_BYTE = 8'haa
) (
    input  logic clk,
    input  logic rstn_i,
    output logic tx_o,
    input  logic rx_i,
    dbg_uart_host_if.slave bus
);
    localparam logic [31:0] CLK_DIV  = 32'(CLK_FREQ / BAUDRATE);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

    typedef enum logic [2:0] {
        IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_DATA, RX_END, RSP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q;
    logic [31:0] addr_q, data_q, rsp_data_q;
    logic [2:0]  byte_cnt;
    logic [31:0] tmo_cnt;
    logic        err_q;

    logic        tx_valid, tx_done;
    logic [7:0]  tx_byte;
    logic        rx_valid, rx_err;
    logic [7:0]  rx_data;
    logic        cmd_ready, rsp_valid, adv, set_err, tmo, in_rx;

    uart_tx u_tx (
        .clk       (clk),
        .rstn_i    (rstn_i),
        .clk_div_i (CLK_DIV),
        .tx_valid_i(tx_valid),
        .tx_data_i (tx_byte),
        .tx_done_o (tx_done),
        .tx_o      (tx_o)
    );

    uart_rx u_rx (
        .clk        (clk),
        .rstn_i     (rstn_i),
        .clk_div_i  (CLK_DIV),
        .rx_enable_i(1'b1),
        .rx_i       (rx_i),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_err_o   (rx_err)
    );

    assign in_rx = (state_q == RX_DATA) || (state_q == RX_END);
    assign tmo   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        tx_valid  = 1'b0;
        tx_byte   = cmd_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        adv       = 1'b0;
        set_err   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid_i) state_d = TX_CMD;
            end
            TX_CMD: begin
                tx_valid = 1'b1;
                if (tx_done) state_d = cmd_q[7] ? TX_ADDR : RX_END;
            end
            TX_ADDR: begin
                tx_valid = 1'b1;
                tx_byte  = addr_q[{byte_cnt[1:0], 3'b000} +: 8];
                if (tx_done) begin
                    adv = 1'b1;
                    if (byte_cnt == 3'd3)
                        state_d = cmd_q[6] ? TX_DATA : RX_DATA;
                end
            end
            TX_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = data_q[{byte_cnt[1:0], 3'b000} +: 8];
                if (tx_done) begin
                    adv = 1'b1;
                    if (byte_cnt == 3'd3) state_d = RX_END;
                end
            end
            RX_DATA: begin
                if (rx_valid) begin
                    adv     = 1'b1;
                    set_err = rx_err;
                    if (byte_cnt == 3'd3) state_d = RX_END;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_d = RSP;
                end
            end
            RX_END: begin
                if (rx_valid) begin
                    set_err = rx_err || (rx_data != END_BYTE);
                    state_d = RSP;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (cmd_ready && bus.cmd_valid_i) begin
                cmd_q  <= bus.cmd_i;
                addr_q <= bus.addr_i;
                data_q <= bus.data_i;
                err_q  <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
            if (state_d != state_q) byte_cnt <= '0;
            else if (adv)           byte_cnt <= byte_cnt + 3'd1;
            // counts idle cycles while waiting on a reply byte
            if (!in_rx || rx_valid) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + 32'd1;
            if (state_q == RX_DATA && rx_valid)
                rsp_data_q[{byte_cnt[1:0], 3'b000} +: 8] <= rx_data;
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = err_q;
endmodule
